// File: rtl/phy_8b10b_pkg.sv
// Shared 8B/10B PHY framing constants, FSM state type and EOF helper.
package phy_8b10b_pkg;

  // Control and data characters used on the framed K/D stream
  localparam logic [7:0] K_COMMA  = 8'hBC;
  localparam logic [7:0] D_COMMA2 = 8'h50;
  localparam logic [7:0] K_SOF    = 8'hFB;
  localparam logic [7:0] K_EOF    = 8'hFD;
  localparam logic [7:0] PAD      = 8'h00;

  // Idle word in big-endian framing order (byte 0 in [31:24], K flag in bit 3)
  localparam logic [31:0] IDLE_WORD = {K_COMMA, D_COMMA2, K_COMMA, D_COMMA2};
  localparam logic [3:0]  IDLE_CHAR = 4'b1010;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StEof,
    StDrop
  } tx_state_e;

  // Held bytes still owed on the EOF word; any non MSB-contiguous keep sends all three
  function automatic logic [1:0] eof_rem(input logic [3:0] keep);
    logic [1:0] rem;
    case (keep)
      4'h8:    rem = 2'd0;
      4'hC:    rem = 2'd1;
      4'hE:    rem = 2'd2;
      default: rem = 2'd3;
    endcase
    return rem;
  endfunction

endpackage

// File: rtl/phy_byte_swap.sv
// Combinational byte reversal of a 32-bit word and its 4 per-byte K flags.
module phy_byte_swap (
  input  logic [31:0] data_i,
  input  logic [3:0]  char_i,
  output logic [31:0] data_o,
  output logic [3:0]  char_o
);

  assign data_o = {data_i[7:0], data_i[15:8], data_i[23:16], data_i[31:24]};
  assign char_o = {char_i[0], char_i[1], char_i[2], char_i[3]};

endmodule

// File: rtl/phy_tx_framer.sv
// GT TX framer: wraps AXIS frames in SOF/EOF K-chars and fills gaps with idle commas.
module phy_tx_framer
  import phy_8b10b_pkg::*;
#(
  parameter int unsigned P_MIN_IDLE = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_link_up,
  input  logic [31:0] i_tx_axis_data,
  input  logic [3:0]  i_tx_axis_keep,
  input  logic        i_tx_axis_valid,
  input  logic        i_tx_axis_last,
  output logic        o_tx_axis_ready,
  output logic [31:0] o_gt_tx_data,
  output logic [3:0]  o_gt_tx_char,
  output logic        o_underrun
);

  localparam logic [3:0] GapMax = 4'(P_MIN_IDLE);

  tx_state_e   state_q, state_d;
  logic [3:0]  gap_q, gap_d;
  logic [23:0] hold_q, hold_d;
  logic [3:0]  keep_q, keep_d;
  logic [31:0] word_d;
  logic [3:0]  char_d;
  logic        underrun_q, underrun_d;
  logic [31:0] gt_data_q, gt_data_d;
  logic [3:0]  gt_char_q, gt_char_d;
  logic        ready;
  logic        accept;

  // AXIS ready depends on state only (plus link gating of frame start)
  always_comb begin
    unique case (state_q)
      StIdle:         ready = i_link_up && (gap_q == GapMax);
      StData, StDrop: ready = 1'b1;
      default:        ready = 1'b0;
    endcase
  end

  assign accept = i_tx_axis_valid && ready;

  // Next state plus the big-endian framing word for the coming cycle
  always_comb begin
    state_d    = state_q;
    gap_d      = gap_q;
    hold_d     = hold_q;
    keep_d     = keep_q;
    word_d     = IDLE_WORD;
    char_d     = IDLE_CHAR;
    underrun_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          word_d  = {K_COMMA, D_COMMA2, K_SOF, i_tx_axis_data[31:24]};
          hold_d  = i_tx_axis_data[23:0];
          keep_d  = i_tx_axis_keep;
          state_d = i_tx_axis_last ? StEof : StData;
        end else if (gap_q != GapMax) begin
          gap_d = gap_q + 4'd1;
        end
      end
      StData: begin
        if (i_tx_axis_valid) begin
          word_d = {hold_q, i_tx_axis_data[31:24]};
          char_d = 4'b0000;
          hold_d = i_tx_axis_data[23:0];
          keep_d = i_tx_axis_keep;
          if (i_tx_axis_last) state_d = StEof;
        end else begin
          // Source starved mid-frame: close the frame with what is held
          word_d     = {hold_q, K_EOF};
          char_d     = 4'b0001;
          underrun_d = 1'b1;
          state_d    = StDrop;
        end
      end
      StEof: begin
        unique case (eof_rem(keep_q))
          2'd0: begin
            word_d = {K_EOF, PAD, PAD, PAD};
            char_d = 4'b1000;
          end
          2'd1: begin
            word_d = {hold_q[23:16], K_EOF, PAD, PAD};
            char_d = 4'b0100;
          end
          2'd2: begin
            word_d = {hold_q[23:8], K_EOF, PAD};
            char_d = 4'b0010;
          end
          default: begin
            word_d = {hold_q, K_EOF};
            char_d = 4'b0001;
          end
        endcase
        gap_d   = '0;
        state_d = StIdle;
      end
      default: begin
        // Discard the rest of an underrun frame
        if (accept && i_tx_axis_last) begin
          gap_d   = '0;
          state_d = StIdle;
        end
      end
    endcase
  end

  phy_byte_swap u_swap (
    .data_i (word_d),
    .char_i (char_d),
    .data_o (gt_data_d),
    .char_o (gt_char_d)
  );

  // State and registered GT outputs; reset drops straight back to idle commas
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= StIdle;
      gap_q      <= '0;
      hold_q     <= '0;
      keep_q     <= '0;
      gt_data_q  <= {D_COMMA2, K_COMMA, D_COMMA2, K_COMMA};
      gt_char_q  <= 4'b0101;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gap_q      <= gap_d;
      hold_q     <= hold_d;
      keep_q     <= keep_d;
      gt_data_q  <= gt_data_d;
      gt_char_q  <= gt_char_d;
      underrun_q <= underrun_d;
    end
  end

  assign o_tx_axis_ready = ready;
  assign o_gt_tx_data    = gt_data_q;
  assign o_gt_tx_char    = gt_char_q;
  assign o_underrun      = underrun_q;

endmodule

// File: tb/tb_phy_tx_framer.sv
// Self-checking bench for phy_tx_framer: byte-stream reference model, per-cycle
// compare, software deframer round trip and literal wire-word checks.
module tb_phy_tx_framer;

  localparam int MIN_IDLE = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        link;
  logic [31:0] tx_data;
  logic [3:0]  tx_keep;
  logic        tx_valid;
  logic        tx_last;
  logic        ready;
  logic [31:0] gt_data;
  logic [3:0]  gt_char;
  logic        underrun;

  phy_tx_framer #(.P_MIN_IDLE(MIN_IDLE)) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_link_up       (link),
    .i_tx_axis_data  (tx_data),
    .i_tx_axis_keep  (tx_keep),
    .i_tx_axis_valid (tx_valid),
    .i_tx_axis_last  (tx_last),
    .o_tx_axis_ready (ready),
    .o_gt_tx_data    (gt_data),
    .o_gt_tx_char    (gt_char),
    .o_underrun      (underrun)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (wire byte stream) ----------------
  typedef struct packed {
    logic [31:0] w;
    logic [3:0]  k;
    logic        u;
  } exp_t;

  exp_t        expq[$];
  logic [8:0]  bq[$];         // {K flag, byte} in wire order
  logic [7:0]  cur[$];        // payload of the frame being sent
  logic [7:0]  sent_bytes[$];
  int          sent_lens[$];
  bit          m_open, m_drop, m_eofp;
  int          m_idle;

  logic [35:0] obs[$];        // non-idle wire words, big-endian view {W,K}
  int          obs_cyc[$];
  int          cyc = 0;
  int          u_cnt = 0;

  logic [7:0]  rx[$];
  int          rx_st = 0;

  function automatic int keep_bytes(input logic [3:0] k);
    case (k)
      4'h8:    return 1;
      4'hC:    return 2;
      4'hE:    return 3;
      default: return 4;
    endcase
  endfunction

  function automatic logic [35:0] obs_at(input int i);
    if (i < obs.size()) return obs[i];
    return '0;
  endfunction

  function automatic int obs_cyc_at(input int i);
    if (i < obs_cyc.size()) return obs_cyc[i];
    return -1000;
  endfunction

  task automatic push_b(input logic [7:0] b, input logic k);
    bq.push_back({k, b});
  endtask

  task automatic emit(input logic u);
    exp_t e;
    logic [8:0] x;
    e.w = '0;
    e.k = '0;
    e.u = u;
    for (int i = 0; i < 4; i++) begin
      x = bq.pop_front();
      e.w = {e.w[23:0], x[7:0]};
      e.k = {e.k[2:0], x[8]};
    end
    expq.push_back(e);
  endtask

  task automatic close_frame();
    sent_lens.push_back(cur.size());
    foreach (cur[i]) sent_bytes.push_back(cur[i]);
    cur.delete();
  endtask

  task automatic take_beat(input logic [31:0] d, input logic [3:0] kp, input logic l);
    int n;
    logic [31:0] t;
    n = l ? keep_bytes(kp) : 4;
    t = d;
    for (int i = 0; i < n; i++) begin
      push_b(t[31:24], 1'b0);
      cur.push_back(t[31:24]);
      t = t << 8;
    end
    emit(1'b0);
    if (l) begin
      push_b(8'hFD, 1'b1);
      while (bq.size() % 4 != 0) push_b(8'h00, 1'b0);
      emit(1'b0);
      close_frame();
      m_eofp = 1'b1;
    end
  endtask

  task automatic model_reset();
    expq.delete(); bq.delete(); cur.delete();
    sent_bytes.delete(); sent_lens.delete(); rx.delete();
    rx_st  = 0;
    m_open = 1'b0;
    m_drop = 1'b0;
    m_eofp = 1'b0;
    m_idle = 0;
  endtask

  // ---------------- software receive deframer ----------------
  task automatic rt_end();
    int el;
    bit same;
    chk("rt_pending", 64'(sent_lens.size() > 0), 64'(1));
    if (sent_lens.size() > 0) begin
      el = sent_lens.pop_front();
      chk("rt_len", 64'(rx.size()), 64'(el));
      same = 1'b1;
      for (int i = 0; i < el; i++) begin
        logic [7:0] b;
        b = sent_bytes.pop_front();
        if (i >= rx.size() || rx[i] !== b) same = 1'b0;
      end
      chk("rt_data", 64'(same), 64'(1));
    end
  endtask

  task automatic deframe(input logic [31:0] w, input logic [3:0] k);
    for (int i = 0; i < 4; i++) begin
      logic [7:0] b;
      logic kk;
      b  = w[31-8*i -: 8];
      kk = k[3-i];
      case (rx_st)
        0: rx_st = (kk && b == 8'hBC) ? 1 : 0;
        1: rx_st = (!kk && b == 8'h50) ? 2 : ((kk && b == 8'hBC) ? 1 : 0);
        2: begin
          if (kk && b == 8'hFB) begin
            rx_st = 3;
            rx.delete();
          end else begin
            rx_st = (kk && b == 8'hBC) ? 1 : 0;
          end
        end
        default: begin
          if (kk && b == 8'hFD) begin
            rt_end();
            rx_st = 0;
          end else begin
            rx.push_back(b);
          end
        end
      endcase
    end
  endtask

  // ---------------- per-cycle compare + model advance ----------------
  always @(negedge clk) begin
    exp_t e;
    logic [31:0] ow;
    logic [3:0] ok;
    logic er;
    cyc++;
    ow = {gt_data[7:0], gt_data[15:8], gt_data[23:16], gt_data[31:24]};
    ok = {gt_char[0], gt_char[1], gt_char[2], gt_char[3]};
    if (!rst_n) begin
      chk("rst_data", 64'(gt_data), 64'h50BC50BC);
      chk("rst_char", 64'(gt_char), 64'(4'b0101));
      chk("rst_ready", 64'(ready), 64'(0));
      chk("rst_underrun", 64'(underrun), 64'(0));
      model_reset();
    end else begin
      if (expq.size() > 0) e = expq.pop_front();
      else e = '{w: 32'hBC50BC50, k: 4'b1010, u: 1'b0};
      chk("word", 64'(ow), 64'(e.w));
      chk("char", 64'(ok), 64'(e.k));
      chk("underrun", 64'(underrun), 64'(e.u));
      if (underrun) u_cnt++;
      if ({ow, ok} != {32'hBC50BC50, 4'b1010}) begin
        obs.push_back({ow, ok});
        obs_cyc.push_back(cyc);
      end
      deframe(ow, ok);
      er = (m_open || m_drop) ? 1'b1 : (m_eofp ? 1'b0 : (link && (m_idle >= MIN_IDLE)));
      chk("ready", 64'(ready), 64'(er));
      if (m_eofp) begin
        m_eofp = 1'b0;
        m_idle = 0;
      end else if (m_open) begin
        if (tx_valid) begin
          take_beat(tx_data, tx_keep, tx_last);
          if (tx_last) m_open = 1'b0;
        end else begin
          push_b(8'hFD, 1'b1);
          emit(1'b1);
          close_frame();
          m_open = 1'b0;
          m_drop = 1'b1;
        end
      end else if (m_drop) begin
        if (tx_valid && tx_last) begin
          m_drop = 1'b0;
          m_idle = 0;
        end
      end else if (tx_valid && er) begin
        push_b(8'hBC, 1'b1);
        push_b(8'h50, 1'b0);
        push_b(8'hFB, 1'b1);
        take_beat(tx_data, tx_keep, tx_last);
        if (!tx_last) m_open = 1'b1;
      end else begin
        m_idle++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    tx_data  = d;
    tx_keep  = k;
    tx_last  = l;
    tx_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      done = ready;
      step();
      n++;
      if (!done && n > 200) begin
        chk("accept_timeout", 64'(done), 64'(1));
        done = 1'b1;
      end
    end
    tx_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] kv [4];
    int cnt;
    kv[0] = 4'h8; kv[1] = 4'hC; kv[2] = 4'hE; kv[3] = 4'hF;
    rst_n = 1'b0; link = 1'b0; tx_valid = 1'b0;
    tx_data = '0; tx_keep = '0; tx_last = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    link  = 1'b1;
    // ready rises only after MIN_IDLE idle cycles
    @(negedge clk); chk("ready_c0", 64'(ready), 64'(0));
    @(negedge clk); chk("ready_c1", 64'(ready), 64'(0));
    @(negedge clk); chk("ready_c2", 64'(ready), 64'(1));
    step();

    // Single beat, keep=F
    obs.delete();
    send_beat(32'h11223344, 4'hF, 1'b1);
    repeat (4) step();
    chk("single_n", 64'(obs.size()), 64'(2));
    chk("single_sof", 64'(obs_at(0)), 64'({32'hBC50FB11, 4'b1010}));
    chk("single_eof", 64'(obs_at(1)), 64'({32'h223344FD, 4'b0001}));

    // Three beats, keep=C on last; junk keep on earlier beats
    obs.delete();
    send_beat(32'hA0A1A2A3, 4'h3, 1'b0);
    send_beat(32'hB0B1B2B3, 4'h0, 1'b0);
    send_beat(32'hC0C1C2C3, 4'hC, 1'b1);
    repeat (4) step();
    chk("three_n", 64'(obs.size()), 64'(4));
    chk("three_w0", 64'(obs_at(0)), 64'({32'hBC50FBA0, 4'b1010}));
    chk("three_w1", 64'(obs_at(1)), 64'({32'hA1A2A3B0, 4'b0000}));
    chk("three_w2", 64'(obs_at(2)), 64'({32'hB1B2B3C0, 4'b0000}));
    chk("three_w3", 64'(obs_at(3)), 64'({32'hC1FD0000, 4'b0100}));

    // Back-to-back frames: exactly MIN_IDLE idle words between EOF and SOF
    repeat (4) step();
    obs.delete();
    obs_cyc.delete();
    send_beat(32'h01234567, 4'hF, 1'b1);
    send_beat(32'h89ABCDEF, 4'h8, 1'b1);
    repeat (4) step();
    chk("b2b_n", 64'(obs.size()), 64'(4));
    chk("b2b_gap", 64'(obs_cyc_at(2) - obs_cyc_at(1)), 64'(MIN_IDLE + 1));
    chk("b2b_sof2", 64'(obs_at(2)), 64'({32'hBC50FB89, 4'b1010}));
    chk("b2b_eof2", 64'(obs_at(3)), 64'({32'hFD000000, 4'b1000}));

    // Link down: ready never rises
    link = 1'b0;
    cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (ready) cnt++;
    end
    chk("linkdown_ready", 64'(cnt), 64'(0));
    step();
    link = 1'b1;

    // Underrun after beat 2 of 4
    obs.delete();
    u_cnt = 0;
    send_beat(32'h01020304, 4'hF, 1'b0);
    send_beat(32'h05060708, 4'hF, 1'b0);
    step();
    send_beat(32'h090A0B0C, 4'hF, 1'b0);
    send_beat(32'h0D0E0F10, 4'h4, 1'b1);
    repeat (4) step();
    chk("urun_n", 64'(obs.size()), 64'(3));
    chk("urun_w0", 64'(obs_at(0)), 64'({32'hBC50FB01, 4'b1010}));
    chk("urun_w1", 64'(obs_at(1)), 64'({32'h02030405, 4'b0000}));
    chk("urun_eof", 64'(obs_at(2)), 64'({32'h060708FD, 4'b0001}));
    chk("urun_pulses", 64'(u_cnt), 64'(1));
    obs.delete();
    send_beat(32'h5A5A5A5A, 4'h8, 1'b1);
    repeat (4) step();
    chk("post_urun_sof", 64'(obs_at(0)), 64'({32'hBC50FB5A, 4'b1010}));
    chk("post_urun_eof", 64'(obs_at(1)), 64'({32'hFD000000, 4'b1000}));

    // Asynchronous reset in the middle of a frame
    send_beat(32'hDEADBEEF, 4'hF, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_data", 64'(gt_data), 64'h50BC50BC);
    chk("arst_char", 64'(gt_char), 64'(4'b0101));
    chk("arst_ready", 64'(ready), 64'(0));
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    obs.delete();
    send_beat(32'hCAFEF00D, 4'hE, 1'b1);
    repeat (4) step();
    chk("post_rst_n", 64'(obs.size()), 64'(2));
    chk("post_rst_sof", 64'(obs_at(0)), 64'({32'hBC50FBCA, 4'b1010}));
    chk("post_rst_eof", 64'(obs_at(1)), 64'({32'hFEF0FD00, 4'b0010}));

    // Round trip of every legal keep value
    for (int i = 0; i < 4; i++) begin
      send_beat($urandom, 4'hF, 1'b0);
      send_beat($urandom, kv[i], 1'b1);
    end

    // Randomized traffic: gaps, link flaps, bubbles (underruns), illegal keeps
    for (int f = 0; f < 60; f++) begin
      int nb;
      int bub;
      int r;
      logic [3:0] lk;
      repeat ($urandom_range(0, 3)) step();
      if ($urandom_range(0, 7) == 0) begin
        link = 1'b0;
        repeat ($urandom_range(1, 6)) step();
        link = 1'b1;
      end
      nb  = $urandom_range(1, 5);
      bub = (nb > 1 && $urandom_range(0, 5) == 0) ? $urandom_range(1, nb - 1) : 0;
      r   = $urandom_range(0, 9);
      case (r)
        0, 1:    lk = 4'h8;
        2, 3:    lk = 4'hC;
        4, 5:    lk = 4'hE;
        6, 7:    lk = 4'hF;
        8:       lk = 4'h5;
        default: lk = 4'h0;
      endcase
      for (int b = 1; b <= nb; b++) begin
        if (b > 1 && $urandom_range(0, 9) == 0) link = 1'b0;
        send_beat($urandom, (b == nb) ? lk : 4'($urandom), (b == nb));
        link = 1'b1;
        if (b == bub) step();
      end
    end

    repeat (10) step();
    chk("rt_drain", 64'(sent_lens.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
